// File: rtl/rmii_pkg.sv
// Shared definitions for the RMII receive deframer.
// Contents: FSM state encodings, preamble/SFD dibit values, CRC-32 constants
// and a byte-wide reflected CRC-32 update helper.
package rmii_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle     = 2'd0;
  localparam state_t StPreamble = 2'd1;
  localparam state_t StPayload  = 2'd2;
  localparam state_t StDrain    = 2'd3;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  // Remainder left in the reflected register after a frame including a good FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Reflected CRC-32 update, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [31:0] p;
    c = crc;
    p = reflect32(CRC32_POLY);
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ p) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator (reflected, init 0xFFFFFFFF, no final xor).
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (register preset to all ones)
//   clr   - restart accumulation (register preset to all ones)
//   en    - fold data into the running CRC this cycle
//   data  - byte to accumulate
//   crc   - registered running CRC
module crc32_d8
  import rmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/rmii_rx.sv
// MAC-side RMII receive deframer. Strips preamble/SFD, assembles LSB-first
// dibits into bytes and presents them with a one-byte holdback so that the
// final byte can be tagged with last/err/len.
// Optional build macro: RMII_RX_CRC_EN adds FCS checking into err.
// Ports:
//   refclk - 50 MHz RMII reference clock
//   rst    - synchronous active-high reset
//   rxd    - receive dibit from PHY
//   rxdv   - receive data valid from PHY
//   d      - received byte (holds when dv=0)
//   dv     - one-cycle strobe, d valid
//   last   - qualifies dv: final byte of frame
//   err    - qualifies last: alignment, overflow (or FCS) error
//   len    - frame byte count, valid with last
module rmii_rx
  import rmii_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 1536,
  parameter int unsigned LEN_W     = 11
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [1:0]       rxd,
  input  logic             rxdv,
  output logic [7:0]       d,
  output logic             dv,
  output logic             last,
  output logic             err,
  output logic [LEN_W-1:0] len
);

  logic [1:0]       rxd_r;
  logic             rxdv_r;
  state_t           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [LEN_W-1:0] bcnt_q, bcnt_d;
  logic [7:0]       held_q, held_d;
  logic [7:0]       d_q, d_d;
  logic             dv_q, dv_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       byte_new;
  logic             crc_bad;

  assign byte_new = {rxd_r, sr_q[7:2]};

`ifdef RMII_RX_CRC_EN
  logic        crc_clr;
  logic        crc_en;
  logic [31:0] crc;

  assign crc_clr = (state_q == StPreamble) && rxdv_r && (rxd_r == SFD_DIBIT);
  assign crc_en  = (state_q == StPayload) && rxdv_r && (dcnt_q == 2'd3);

  crc32_d8 u_crc (
    .clk  (refclk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (byte_new),
    .crc  (crc)
  );

  assign crc_bad = (crc != CRC32_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    held_d  = held_q;
    d_d     = d_q;
    dv_d    = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    len_d   = len_q;

    case (state_q)
      StIdle: begin
        if (rxdv_r) begin
          state_d = (rxd_r == PRE_DIBIT) ? StPreamble : StDrain;
        end
      end
      StPreamble: begin
        if (!rxdv_r) begin
          state_d = StIdle;
        end else if (rxd_r == SFD_DIBIT) begin
          state_d = StPayload;
          dcnt_d  = 2'd0;
          bcnt_d  = '0;
          sr_d    = '0;
        end else if (rxd_r != PRE_DIBIT) begin
          state_d = StDrain;
        end
      end
      StPayload: begin
        if (rxdv_r) begin
          sr_d   = byte_new;
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            if (bcnt_q == LEN_W'(MAX_BYTES)) begin
              // Byte MAX_BYTES+1 arrived: close the frame on the held byte.
              d_d     = held_q;
              dv_d    = 1'b1;
              last_d  = 1'b1;
              err_d   = 1'b1;
              len_d   = bcnt_q;
              state_d = StDrain;
            end else begin
              if (bcnt_q != '0) begin
                d_d  = held_q;
                dv_d = 1'b1;
              end
              held_d = byte_new;
              bcnt_d = bcnt_q + LEN_W'(1);
            end
          end
        end else begin
          state_d = StIdle;
          if (bcnt_q != '0) begin
            d_d    = held_q;
            dv_d   = 1'b1;
            last_d = 1'b1;
            len_d  = bcnt_q;
            err_d  = (dcnt_q != 2'd0) || crc_bad;
          end
        end
      end
      StDrain: begin
        if (!rxdv_r) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      rxd_r   <= '0;
      rxdv_r  <= 1'b0;
      state_q <= StIdle;
      sr_q    <= '0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      held_q  <= '0;
      d_q     <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      rxd_r   <= rxd;
      rxdv_r  <= rxdv;
      state_q <= state_d;
      sr_q    <= sr_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      held_q  <= held_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  assign d    = d_q;
  assign dv   = dv_q;
  assign last = last_q;
  assign err  = err_q;
  assign len  = len_q;

endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx: two instances (default size and MAX_BYTES=16)
// share one RMII input stream; received bytes are logged and compared
// against the bytes each frame was built from.
module tb_rmii_rx;

`ifdef RMII_RX_CRC_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  logic [1:0]  rxd    = 2'b00;
  logic        rxdv   = 1'b0;

  logic [7:0]  d_a, d_o;
  logic        dv_a, dv_o, last_a, last_o, err_a, err_o;
  logic [10:0] len_a;
  logic [4:0]  len_o;

  always #10 refclk = ~refclk;

  rmii_rx #(.MAX_BYTES(1536), .LEN_W(11)) dut_a (
    .refclk (refclk), .rst (rst), .rxd (rxd), .rxdv (rxdv),
    .d (d_a), .dv (dv_a), .last (last_a), .err (err_a), .len (len_a)
  );

  rmii_rx #(.MAX_BYTES(16), .LEN_W(5)) dut_o (
    .refclk (refclk), .rst (rst), .rxd (rxd), .rxdv (rxdv),
    .d (d_o), .dv (dv_o), .last (last_o), .err (err_o), .len (len_o)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        last;
    logic        err;
    logic [10:0] len;
    logic [31:0] cyc;
  } rec_t;

  rec_t        a_q[$];
  rec_t        o_q[$];
  logic [2:0]  tx_q[$];   // {dv, dibit}
  logic [7:0]  exp_q[$];
  logic [7:0]  pay[60];

  int unsigned cyc      = 0;
  int          n_vec    = 0;
  int          n_err    = 0;
  bit          rst_s    = 1'b0;
  int          rst_at   = -100;
  int unsigned end_cyc  = 0;
  rec_t        ra, ro;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge refclk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  always @(negedge refclk) begin
    if (rst_s) begin
      check_eq("rst_out_a", 32'({d_a, dv_a, last_a, err_a, len_a}), 32'h0);
      check_eq("rst_out_o", 32'({d_o, dv_o, last_o, err_o, len_o}), 32'h0);
    end
    if (dv_a) begin
      ra.d = d_a; ra.last = last_a; ra.err = err_a; ra.len = len_a; ra.cyc = cyc;
      a_q.push_back(ra);
    end
    if (dv_o) begin
      ro.d = d_o; ro.last = last_o; ro.err = err_o; ro.len = 11'(len_o); ro.cyc = cyc;
      o_q.push_back(ro);
    end
  end

  task automatic push_dibit(input logic v, input logic [1:0] x);
    tx_q.push_back({v, x});
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) push_dibit(1'b1, b[2*k +: 2]);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) push_dibit(1'b0, 2'b00);
  endtask

  task automatic push_pre();
    for (int k = 0; k < 7; k++) push_byte(8'h55);
    push_byte(8'hD5);
  endtask

  task automatic payload(input logic [7:0] b);
    push_byte(b);
    exp_q.push_back(b);
  endtask

  task automatic send();
    logic prev_dv;
    prev_dv = 1'b0;
    push_idle(12);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge refclk);
      #1;
      rst  = (i >= rst_at) && (i < rst_at + 3);
      rxdv = tx_q[i][2];
      rxd  = tx_q[i][1:0];
      if (prev_dv && !rxdv) end_cyc = cyc;
      prev_dv = rxdv;
    end
    rst = 1'b0;
    tx_q.delete();
    rst_at = -100;
  endtask

  task automatic clear_logs();
    a_q.delete();
    o_q.delete();
    exp_q.delete();
  endtask

  task automatic check_frame(input string tag, input int sel, input int n, input int exp_len,
                             input logic exp_err);
    int sz;
    rec_t r;
    sz = sel ? o_q.size() : a_q.size();
    check_eq({tag, "_count"}, sz, n);
    for (int i = 0; i < sz && i < n; i++) begin
      r = sel ? o_q[i] : a_q[i];
      check_eq({tag, "_d"}, r.d, exp_q[i]);
      check_eq({tag, "_last"}, r.last, 32'(i == n - 1));
      if (i == n - 1) begin
        check_eq({tag, "_err"}, r.err, exp_err);
        check_eq({tag, "_len"}, r.len, exp_len);
      end
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x[0] ^ b[i]) ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    return x;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] crc;
    logic [31:0] fcs;

    rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;

    // Reset in the middle of a frame: nothing emitted, remainder drained.
    push_pre();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    for (int k = 0; k < 4; k++) push_byte(8'h00);
    rst_at = 40;
    send();
    check_eq("rstmid_cnt_a", a_q.size(), 0);
    check_eq("rstmid_cnt_o", o_q.size(), 0);
    clear_logs();

    // Nominal three-byte frame.
    push_idle(2);
    push_pre();
    payload(8'h01); payload(8'h02); payload(8'hAB);
    send();
    check_frame("nom_a", 0, 3, 3, 1'b0);
    check_frame("nom_o", 1, 3, 3, 1'b0);
    if (a_q.size() == 3) begin
      check_eq("nom_gap", a_q[1].cyc - a_q[0].cyc, 4);
      check_eq("nom_last_cyc", a_q[2].cyc, end_cyc + 2);
    end
    clear_logs();

    // Bad preamble frame, 1-cycle gap, then a good frame.
    push_byte(8'h55); push_byte(8'h54);
    for (int k = 0; k < 5; k++) push_byte(8'h55);
    push_byte(8'hD5);
    push_byte(8'h10); push_byte(8'h20); push_byte(8'h30);
    push_idle(1);
    push_pre();
    payload(8'hC0); payload(8'hFF); payload(8'hEE);
    send();
    check_frame("badpre_a", 0, 3, 3, 1'b0);
    clear_logs();

    // Alignment error: two bytes plus a stray dibit.
    push_pre();
    payload(8'h5A); payload(8'hC3);
    push_dibit(1'b1, 2'b10);
    send();
    check_frame("align_a", 0, 2, 2, 1'b1);
    check_frame("align_o", 1, 2, 2, 1'b1);
    clear_logs();

    // 20-byte frame: overflows the 16-byte instance only.
    push_pre();
    for (int k = 0; k < 20; k++) payload(8'(k * 7 + 3));
    send();
    check_frame("ovf_o", 1, 16, 16, 1'b1);
    check_frame("ovf_a", 0, 20, 20, 1'b0);
    clear_logs();

    // 60-byte payload with correct FCS.
    crc = 32'hFFFF_FFFF;
    for (int k = 0; k < 60; k++) begin
      pay[k] = 8'(k * 13 + 1);
      crc = crc_upd(crc, pay[k]);
    end
    fcs = ~crc;
    push_pre();
    for (int k = 0; k < 60; k++) payload(pay[k]);
    for (int k = 0; k < 4; k++) payload(fcs[8*k +: 8]);
    send();
    check_frame("crc_ok", 0, 64, 64, 1'b0);
    clear_logs();

    // Same frame with one payload bit flipped.
    push_pre();
    for (int k = 0; k < 60; k++) payload((k == 10) ? (pay[k] ^ 8'h01) : pay[k]);
    for (int k = 0; k < 4; k++) payload(fcs[8*k +: 8]);
    send();
    check_frame("crc_bad", 0, 64, 64, CrcEn);
    clear_logs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
